seg7_scan_driver: RTL and testbench
===================================

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, meaning clk cycles each digit stays selected (1 ms at 100 MHz); legal range 2..2^20.
REQ-002 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port value  input  16  hex value to display; nibble i drives digit i, where digit 0 is rightmost.
REQ-005 SHALL have port dp_in  input  4  decimal point request per digit, active-high.
REQ-006 SHALL have port load  input  1  single-cycle strobe; captures value and dp_in.
REQ-007 SHALL have port en  input  1  display enable; 0 blanks all digits.
REQ-008 SHALL have port an  output  4  digit anodes, active-low, one-hot-low when lit.
REQ-009 SHALL have port seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-010 SHALL have port dp  output  1  decimal point, active-low.

Function
REQ-011 SHALL hold a 16-bit shadow register and a 4-bit dp shadow; both update on the clock edge where load=1, otherwise hold.
REQ-012 SHALL run a refresh counter 0..REFRESH_DIV-1; at REFRESH_DIV-1 it wraps to 0 and digit index advances 0->1->2->3->0.
REQ-013 SHALL make an/seg/dp registered outputs, computed from the digit index and shadow registers as they are before the edge (one-cycle latency).
REQ-014 SHALL drive an = ~(1<<idx) when en=1, and 4'b1111 when en=0; seg=7'h7F and dp=1 when en=0.
REQ-015 SHALL decode nibbles: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E (hex, active-low).
REQ-016 SHALL drive dp = ~dp_shadow[idx] for the lit digit.
REQ-017 SHALL have load coincident with a digit advance take effect from the next output update; digits are never shown torn within one slot.
REQ-018 SHALL let en not affect the counter or index; scanning continues while blanked.
REQ-019 SHALL reach an output change to a new load no later than 2 cycles for the current digit, and within 4*REFRESH_DIV+1 cycles for all digits.

Reset
REQ-020 SHALL apply reset as counter=0, idx=0, shadow=16'h0000, dp shadow=4'h0, an=4'b1111, seg=7'h7F, dp=1.
REQ-021 SHALL let reset win over load and en in the same cycle.
REQ-022 SHALL return the block to the REQ-020 state on reset mid-scan, and start again from digit 0.
REQ-023 SHALL show digit 0 with "0" (an=1110, seg=40) on the first edge after reset release with en=1.

Configuration
REQ-024 SHALL support macro SEG7_LEADING_ZERO_BLANK_EN; when defined, digit i>0 is blanked (an bit high, seg=7F, dp=1) during its slot if shadow nibbles i..3 are all zero.
REQ-025 SHALL ensure, with SEG7_LEADING_ZERO_BLANK_EN defined, that digit 0 is never blanked and that dp_shadow[i]=1 suppresses blanking of digit i.
REQ-026 SHALL light all four digits normally when SEG7_LEADING_ZERO_BLANK_EN is undefined.

Verification (REFRESH_DIV=4)
REQ-027 SHALL verify: reset then en=1 -> an sequence 1110,1101,1011,0111,1110 changing every 4 cycles, seg=40 throughout.
REQ-028 SHALL verify: load value=16'hA5F3, dp_in=4'b0100 -> seg per slot 30,0E,12,08 for digits 0..3, with dp=0 only on digit 2.
REQ-029 SHALL verify: load 16'h1234 in the cycle counter=3 at idx=1 -> digit 2 slot shows seg=24, with no stale value after the advance.
REQ-030 SHALL verify: en=0 for 10 cycles mid-scan -> an=1111 and seg=7F; on re-enable, idx continues from its free-running position.
REQ-031 SHALL verify: with the macro defined, value=16'h0007 -> digits 1..3 have an high; digit 0 seg=78; value=16'h0000 -> digit 0 seg=40.
REQ-032 SHALL verify: reset asserted with load=1 at idx=2 -> all outputs match REQ-020, and shadow stays 0.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed driver for a 4-digit, 7-segment hex display.
// Ports:
//   clk    - system clock, all state on the rising edge
//   reset  - synchronous, active-high
//   value  - 16-bit hex value, nibble i shown on digit i (digit 0 rightmost)
//   dp_in  - per-digit decimal point request, active-high
//   load   - single-cycle strobe capturing value and dp_in
//   en     - display enable; 0 blanks all digits while scanning continues
//   an     - digit anodes, active-low, one-hot-low when lit
//   seg    - segments {g,f,e,d,c,b,a}, active-low
//   dp     - decimal point, active-low
// Optional macro SEG7_LEADING_ZERO_BLANK_EN: blanks leading-zero digits above digit 0
// unless that digit's decimal point is requested.
module seg7_scan_driver #(
   parameter int REFRESH_DIV = 100000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] value,
   input  logic [3:0]  dp_in,
   input  logic        load,
   input  logic        en,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp
);
   localparam int CW = $clog2(REFRESH_DIV);
   logic [CW-1:0] cnt;
   logic [1:0]    idx;
   logic [15:0]   shadow;
   logic [3:0]    dp_shadow;
   logic [3:0]    nib;
   logic [6:0]    glyph;
   logic          wrap;
   logic          lit;
   function automatic logic [6:0] decode(input logic [3:0] n);
      case (n)
         4'h0: decode = 7'h40;
         4'h1: decode = 7'h79;
         4'h2: decode = 7'h24;
         4'h3: decode = 7'h30;
         4'h4: decode = 7'h19;
         4'h5: decode = 7'h12;
         4'h6: decode = 7'h02;
         4'h7: decode = 7'h78;
         4'h8: decode = 7'h00;
         4'h9: decode = 7'h10;
         4'hA: decode = 7'h08;
         4'hB: decode = 7'h03;
         4'hC: decode = 7'h46;
         4'hD: decode = 7'h21;
         4'hE: decode = 7'h06;
         default: decode = 7'h0E;
      endcase
   endfunction
   always_comb begin
      nib   = shadow[{idx, 2'b00} +: 4];
      glyph = decode(nib);
      wrap  = cnt == CW'(REFRESH_DIV - 1);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      // Shifting the shadow down by the digit position leaves nibbles idx..3;
      // all-zero means this digit is a leading zero.
      lit = en && (idx == 2'd0 || dp_shadow[idx] || (shadow >> {idx, 2'b00}) != 16'h0000);
`else
      lit = en;
`endif
   end
   // Outputs use the pre-edge idx/shadow, so a load or digit advance on this
   // edge shows up one cycle later and a slot is never torn.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt       <= '0;
         idx       <= 2'd0;
         shadow    <= 16'h0000;
         dp_shadow <= 4'h0;
         an        <= 4'hF;
         seg       <= 7'h7F;
         dp        <= 1'b1;
      end else begin
         if (load) begin
            shadow    <= value;
            dp_shadow <= dp_in;
         end
         cnt <= wrap ? '0 : cnt + 1'b1;
         if (wrap) idx <= idx + 2'd1;
         an  <= lit ? ~(4'b0001 << idx) : 4'hF;
         seg <= lit ? glyph : 7'h7F;
         dp  <= lit ? ~dp_shadow[idx] : 1'b1;
      end
   end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: self-checking bench for seg7_scan_driver with REFRESH_DIV=4.
// Follows SEG7_LEADING_ZERO_BLANK_EN the same way as the design build.
module tb_seg7_scan_driver;
   localparam int DIV = 4;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] value = 16'h0;
   logic [3:0]  dp_in = 4'h0;
   logic        load = 1'b0;
   logic        en = 1'b0;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;
   int n_checks = 0;
   int n_fail = 0;
   // reference model: cycles since reset plus captured nibbles
   int          m_t = 0;
   logic [15:0] m_sh = 16'h0;
   logic [3:0]  m_dps = 4'h0;
   int          last_idx = 0;
   logic [6:0]  seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
   logic [3:0]  an_seq [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
   typedef struct {
      logic [15:0]     value;
      logic [3:0]      dpi;
      logic [3:0][6:0] segs;
   } vec_t;
   vec_t vecs [5];
   seg7_scan_driver #(.REFRESH_DIV(DIV)) dut (
      .clk(clk), .reset(reset), .value(value), .dp_in(dp_in),
      .load(load), .en(en), .an(an), .seg(seg), .dp(dp)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [11:0] act, input logic [11:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h required %h (t=%0d)", name, act, req, m_t);
      end
   endtask
   // One clock: drive inputs, predict outputs from the pre-edge model, advance, compare.
   task automatic tick(input logic r, input logic l, input logic e,
                       input logic [15:0] v, input logic [3:0] d);
      int i;
      logic lit;
      logic [3:0] ea;
      logic [6:0] es;
      logic ed;
      reset = r; load = l; en = e; value = v; dp_in = d;
      i = (m_t / DIV) % 4;
      lit = e && !r;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      if (i > 0 && (m_sh >> (4 * i)) == 16'h0 && !m_dps[i]) lit = 1'b0;
`endif
      ea = lit ? ~(4'b0001 << i) : 4'hF;
      es = lit ? seg_tab[(m_sh >> (4 * i)) & 16'hF] : 7'h7F;
      ed = lit ? ~m_dps[i] : 1'b1;
      last_idx = i;
      @(posedge clk);
      if (r) begin
         m_t = 0; m_sh = 16'h0; m_dps = 4'h0;
      end else begin
         m_t++;
         if (l) begin m_sh = v; m_dps = d; end
      end
      #1;
      chk("model", {an, seg, dp}, {ea, es, ed});
   endtask
   initial begin
      vecs[0] = '{16'hA5F3, 4'b0100, {7'h08, 7'h12, 7'h0E, 7'h30}};
      vecs[1] = '{16'h1234, 4'b0000, {7'h79, 7'h24, 7'h30, 7'h19}};
      vecs[2] = '{16'hFEDC, 4'b1111, {7'h0E, 7'h06, 7'h21, 7'h46}};
      vecs[3] = '{16'h8096, 4'b1001, {7'h00, 7'h40, 7'h10, 7'h02}};
      vecs[4] = '{16'hB07E, 4'b0010, {7'h03, 7'h40, 7'h78, 7'h06}};
      // reset state, then the power-up scan showing "0" on every digit
      tick(1, 0, 1, 16'h0, 4'h0);
      chk("reset_state", {an, seg, dp}, {4'hF, 7'h7F, 1'b1});
      for (int k = 0; k < 20; k++) begin
         tick(0, 0, 1, 16'h0, 4'h0);
         chk("scan_an", {8'h0, an}, {8'h0, an_seq[(k / DIV) % 4]});
         chk("scan_seg", {5'h0, seg}, {5'h0, 7'h40});
      end
      // table of loaded values, each digit slot checked against constants
      foreach (vecs[n]) begin
         tick(1, 0, 1, 16'h0, 4'h0);
         tick(0, 1, 1, vecs[n].value, vecs[n].dpi);
         for (int c = 0; c < 16; c++) begin
            tick(0, 0, 1, 16'hDEAD, 4'hF);
            chk("table_seg", {5'h0, seg}, {5'h0, vecs[n].segs[last_idx]});
            chk("table_dp", {11'h0, dp}, {11'h0, ~vecs[n].dpi[last_idx]});
         end
      end
      // load coincident with the idx 1 -> 2 advance
      tick(1, 0, 1, 16'h0, 4'h0);
      for (int c = 0; c < 7; c++) tick(0, 0, 1, 16'h0, 4'h0);
      tick(0, 1, 1, 16'h1234, 4'h0);
      chk("adv_load_old", {an, seg, dp}, {4'b1101, 7'h40, 1'b1});
      tick(0, 0, 1, 16'h0, 4'h0);
      chk("adv_load_new", {an, seg, dp}, {4'b1011, 7'h24, 1'b1});
      // blank for 10 cycles mid-scan, scanning continues underneath
      for (int c = 0; c < 10; c++) begin
         tick(0, 0, 0, 16'h0, 4'h0);
         chk("blank", {an, seg, dp}, {4'hF, 7'h7F, 1'b1});
      end
      tick(0, 0, 1, 16'h0, 4'h0);
      chk("reenable_an", {8'h0, an}, {8'h0, an_seq[(18 / DIV) % 4]});
      // reset beats load at idx 2
      tick(1, 0, 1, 16'h0, 4'h0);
      for (int c = 0; c < 9; c++) tick(0, 1, 1, 16'h1111, 4'hF);
      tick(1, 1, 1, 16'hFFFF, 4'hF);
      chk("reset_load", {an, seg, dp}, {4'hF, 7'h7F, 1'b1});
      tick(0, 0, 1, 16'h0, 4'h0);
      chk("reset_shadow", {an, seg, dp}, {4'b1110, 7'h40, 1'b1});
      // leading-zero handling
      tick(1, 0, 1, 16'h0, 4'h0);
      tick(0, 1, 1, 16'h0007, 4'h0);
      for (int c = 0; c < 16; c++) begin
         tick(0, 0, 1, 16'h0, 4'h0);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
         chk("lz_0007", {an, seg}, last_idx == 0 ? {4'b1110, 7'h78} : {4'hF, 7'h7F});
`else
         chk("lz_0007", {an, seg}, {an_seq[last_idx], last_idx == 0 ? 7'h78 : 7'h40});
`endif
      end
      tick(0, 1, 1, 16'h0000, 4'b0100);
      for (int c = 0; c < 16; c++) begin
         tick(0, 0, 1, 16'h0, 4'h0);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
         chk("lz_0000", {an, seg}, (last_idx == 0 || last_idx == 2) ? {an_seq[last_idx], 7'h40} : {4'hF, 7'h7F});
`else
         chk("lz_0000", {an, seg}, {an_seq[last_idx], 7'h40});
`endif
      end
      // randomized traffic against the model
      for (int c = 0; c < 400; c++)
         tick($urandom_range(0, 63) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 5) != 0,
              16'($urandom), 4'($urandom));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
